// File: rtl/alu_pkg.sv
// Shared opcode, state and select encodings for the 2-bit ALU accumulator sequencer.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLRF = 2'b11;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    localparam int CMD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] data;
    } cmd_t;

    // A SUB by zero bypasses the ALU, so only non-zero SUBs steer it to subtract.
    function automatic logic uses_alu_sub(input cmd_t cmd);
        return (cmd.op == OP_SUB) && (cmd.data != 2'b00);
    endfunction

endpackage

// File: rtl/alu_2bit_accum_ctrl_fifo.sv
// Small synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_2bit_accum_ctrl.sv
// Sequencer around an external 2-bit ALU: queues commands, executes one at a time
// against the accumulator and hands each result downstream over valid/ready.
module alu_2bit_accum_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_data,
    output logic [1:0] alu_in1,
    output logic [1:0] alu_in2,
    output logic       alu_sel,
    input  logic [1:0] alu_result,
    input  logic       alu_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_result,
    output logic       out_carry,
    output logic       out_sticky
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] acc_r;
    logic [1:0] exec_op_r;
    logic [1:0] exec_data_r;
    logic       sel_r;
    logic       out_valid_r;
    logic       carry_r;
    logic       sticky_r;
    logic [1:0] acc_nxt_s;
    logic       carry_nxt_s;
    logic       sticky_nxt_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       push_s;
    logic       pop_s;
    cmd_t       wr_cmd_s;
    cmd_t       head_s;

    assign wr_cmd_s = '{op: cmd_op, data: cmd_data};
    assign push_s   = cmd_valid && !fifo_full_s;
    assign pop_s    = (state_r == ST_IDLE) && !fifo_empty_s;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .wr_data (wr_cmd_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Next-state logic for the IDLE/EXEC/RESP sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result of the executing command; SUB by zero bypasses the ALU magnitude path
    always_comb begin
        acc_nxt_s    = acc_r;
        carry_nxt_s  = 1'b0;
        sticky_nxt_s = sticky_r;
        case (exec_op_r)
            OP_ADD: begin
                acc_nxt_s   = alu_result;
                carry_nxt_s = alu_carry;
            end
            OP_SUB: begin
                if (exec_data_r != 2'b00) begin
                    acc_nxt_s   = alu_result;
                    carry_nxt_s = alu_carry;
                end else begin
                    acc_nxt_s   = acc_r;
                    carry_nxt_s = 1'b0;
                end
            end
            OP_LOAD: begin
                acc_nxt_s   = exec_data_r;
                carry_nxt_s = 1'b0;
            end
            OP_CLRF: begin
                acc_nxt_s   = acc_r;
                carry_nxt_s = 1'b0;
            end
            default: begin
                acc_nxt_s   = acc_r;
                carry_nxt_s = 1'b0;
            end
        endcase
        if (exec_op_r == OP_CLRF) begin
            sticky_nxt_s = 1'b0;
        end else begin
            sticky_nxt_s = sticky_r | carry_nxt_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command capture, accumulator and output handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= 2'b00;
            exec_op_r   <= OP_ADD;
            exec_data_r <= 2'b00;
            sel_r       <= SEL_ADD;
            out_valid_r <= 1'b0;
            carry_r     <= 1'b0;
            sticky_r    <= 1'b0;
        end else begin
            if (pop_s) begin
                exec_op_r   <= head_s.op;
                exec_data_r <= head_s.data;
                sel_r       <= uses_alu_sub(head_s) ? SEL_SUB : SEL_ADD;
            end
            if (state_r == ST_EXEC) begin
                acc_r       <= acc_nxt_s;
                carry_r     <= carry_nxt_s;
                sticky_r    <= sticky_nxt_s;
                out_valid_r <= 1'b1;
                sel_r       <= SEL_ADD;
            end else if ((state_r == ST_RESP) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign cmd_ready  = !fifo_full_s;
    assign alu_in1    = acc_r;
    assign alu_in2    = exec_data_r;
    assign alu_sel    = sel_r;
    assign out_valid  = out_valid_r;
    assign out_result = acc_r;
    assign out_carry  = carry_r;
    assign out_sticky = sticky_r;

endmodule
